// File: rtl/approx_mul_seq.sv
// Sequential shift-add unsigned multiplier, one partial-product row per clock,
// with per-transaction approximate low columns. Optional macro: ZERO_SKIP_EN.
module approx_mul_seq #(
  parameter int unsigned W1          = 8,
  parameter int unsigned W2          = 8,
  parameter int unsigned APPROX_COLS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W1-1:0]    in_a,
  input  logic [W2-1:0]    in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W1+W2-1:0] out_p
);

  localparam int unsigned PW = W1 + W2;
  localparam int unsigned KW = (W2 > 1) ? $clog2(W2) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   acc, acc_d;
  logic [KW-1:0]   k, k_d;
  logic [W1-1:0]   a_q, a_d;
  logic [W2-1:0]   b_q, b_d;
  logic            approx_q, approx_d;
  logic            in_ready_d, out_valid_d;
  logic [PW-1:0]   out_p_d;
  logic [PW-1:0]   row_c;
  logic [PW-1:0]   sum_c;
  logic            last_c;

  // Ripple row adder; low columns use the OR/AND cell when approx is set.
  function automatic logic [PW-1:0] row_add(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y,
                                            input logic          approx);
    logic [PW-1:0] s;
    logic          c;
    s = '0;
    c = 1'b0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (approx && (i < APPROX_COLS)) begin
        s[i] = x[i] | y[i] | c;
        c    = x[i] & y[i] & c;
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
    end
    return s;
  endfunction

  always_comb begin
    row_c  = b_q[k] ? (PW'(a_q) << k) : '0;
    sum_c  = row_add(acc, row_c, approx_q);
    last_c = (k == KW'(W2 - 1));
`ifdef ZERO_SKIP_EN
    // Stop early once no set multiplier bits remain above row k.
    if (((b_q >> k) >> 1) == '0) last_c = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      approx_q  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      k         <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      approx_q  <= approx_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_p     <= out_p_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    k_d         = k;
    a_d         = a_q;
    b_d         = b_q;
    approx_d    = approx_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_p_d     = out_p;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d        = in_a;
          b_d        = in_b;
          approx_d   = in_approx;
          acc_d      = '0;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = sum_c;
        k_d   = k + KW'(1);
        if (last_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_p_d     = sum_c;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed self-checking bench for approx_mul_seq at default parameters.
module tb_approx_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_approx;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int passed = 0;
  int total  = 0;

  approx_mul_seq #(.W1(8), .W2(8), .APPROX_COLS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present operands for one accept edge; returns #1 after that edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ap);
    in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ap, input logic [15:0] exp);
    int lat;
    start_op(a, b, ap);
    wait_valid(lat);
    check(tag, 32'(out_p), 32'(exp));
    finish_op();
  endtask

  initial begin
    int lat;
    int exp_lat;
    logic [7:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_p", 32'(out_p), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 3*3 approximate: low columns OR together -> 7, with latency check.
    start_op(8'd3, 8'd3, 1'b1);
    check("accept_drops_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
`ifdef ZERO_SKIP_EN
    exp_lat = 2;
`else
    exp_lat = 8;
`endif
    check("latency_3x3", 32'(lat), 32'(exp_lat));
    check("approx_3x3", 32'(out_p), 32'd7);
    finish_op();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    run_op("exact_3x3", 8'd3, 8'd3, 1'b0, 16'd9);
    run_op("exact_255x255", 8'd255, 8'd255, 1'b0, 16'd65025);
    run_op("approx_255x1", 8'd255, 8'd1, 1'b1, 16'd255);
    run_op("approx_255x3", 8'd255, 8'd3, 1'b1, 16'd703);
    run_op("approx_7x7", 8'd7, 8'd7, 1'b1, 16'd31);
    run_op("exact_0x200", 8'd0, 8'd200, 1'b0, 16'd0);
    run_op("approx_200x0", 8'd200, 8'd0, 1'b1, 16'd0);
    run_op("exact_1x128", 8'd1, 8'd128, 1'b0, 16'd128);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      run_op("exact_random", ra, rb, 1'b0, 16'(ra) * 16'(rb));
    end

    // Backpressure: result held, new operands ignored until in_ready returns.
    start_op(8'd12, 8'd13, 1'b0);
    wait_valid(lat);
    check("bp_result", 32'(out_p), 32'd156);
    in_a = 8'd200; in_b = 8'd2; in_approx = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_p_stable", 32'(out_p), 32'd156);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    finish_op();
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("bp_next_result", 32'(out_p), 32'd400);
    finish_op();

    // Reset during row 4 aborts immediately.
    start_op(8'd99, 8'd255, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_run_no_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_p", 32'(out_p), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_abort_10x10", 8'd10, 8'd10, 1'b0, 16'd100);

`ifdef ZERO_SKIP_EN
    start_op(8'd77, 8'd0, 1'b1);
    wait_valid(lat);
    check("zs_b0_latency", 32'(lat), 32'd1);
    check("zs_b0_result", 32'(out_p), 32'd0);
    finish_op();
    start_op(8'd77, 8'd128, 1'b0);
    wait_valid(lat);
    check("zs_b80_latency", 32'(lat), 32'd8);
    check("zs_b80_result", 32'(out_p), 32'd9856);
    finish_op();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
